spram_stream_ctrl: RTL and testbench

SPRAM_STREAM_CTRL -- requirements
Module: spram_stream_ctrl

---
 rtl/spram_stream_ctrl.sv | 141 ++++++++++++++
 tb/tb_spram_stream_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spram_stream_ctrl.sv
// Frame buffer controller for one external single-port RAM: fill from the input stream, then drain in order.
// Optional replay of the stored frame is compiled in with `define SPRAM_STREAM_REPLAY_EN.
module spram_stream_ctrl #(
  parameter int AWIDTH    = 11,
  parameter int NUM_WORDS = 2048,
  parameter int DWIDTH    = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  input  logic              replay,
  output logic              busy,
  output logic [AWIDTH:0]   frame_len,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_data,
  input  logic [DWIDTH-1:0] ram_out
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;

  state_e              state_q;
  logic [AWIDTH-1:0]   wr_ptr_q;
  logic [AWIDTH:0]     rd_ptr_q;
  logic [AWIDTH:0]     frame_len_q;
  logic                rd_inflight_q;
  logic                rd_last_q;
  logic [DWIDTH-1:0]   fifo_data_q [2];
  logic [1:0]          fifo_last_q;
  logic                fifo_wr_idx_q;
  logic                fifo_rd_idx_q;
  logic [1:0]          fifo_cnt_q;
  logic [1:0]          fifo_cnt_d;

  logic                accept;
  logic                end_of_frame;
  logic                pop;
  logic                rd_en;
  logic                rd_is_last;
  logic                replay_go;
  logic [2:0]          occupancy;
  logic [AWIDTH:0]     word_cnt;

  assign in_ready     = !reset && (state_q != DRAIN);
  assign accept       = in_valid && in_ready;
  assign word_cnt     = {1'b0, wr_ptr_q} + (AWIDTH+1)'(1);
  assign end_of_frame = accept && (in_last || (wr_ptr_q == AWIDTH'(NUM_WORDS - 1)));

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[fifo_rd_idx_q];
  assign out_last  = out_valid && fifo_last_q[fifo_rd_idx_q];
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q == DRAIN);
  assign frame_len = frame_len_q;

  // Words already buffered plus words still coming back from the RAM must never exceed the 2 FIFO slots.
  assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
  assign rd_en      = (state_q == DRAIN) && (rd_ptr_q < frame_len_q) && (occupancy < 3'd2);
  assign rd_is_last = (rd_ptr_q == frame_len_q - (AWIDTH+1)'(1));

`ifdef SPRAM_STREAM_REPLAY_EN
  assign replay_go = (state_q == IDLE) && replay && !in_valid && (frame_len_q != '0);
`else
  logic unused_replay;
  assign unused_replay = replay;
  assign replay_go     = 1'b0;
`endif

  assign ram_wren    = accept;
  assign ram_address = (state_q == DRAIN) ? rd_ptr_q[AWIDTH-1:0] : wr_ptr_q;
  assign ram_data    = in_data;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (rd_inflight_q && !pop)      fifo_cnt_d = fifo_cnt_q + 2'd1;
    else if (!rd_inflight_q && pop) fifo_cnt_d = fifo_cnt_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_len_q   <= '0;
      rd_inflight_q <= 1'b0;
      rd_last_q     <= 1'b0;
      // NOTE: the two FIFO slots are reset because out_data must read zero during reset; bulk RAM is not.
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_wr_idx_q  <= 1'b0;
      fifo_rd_idx_q  <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept)         state_q <= end_of_frame ? DRAIN : FILL;
          else if (replay_go) state_q <= DRAIN;
        end
        FILL: begin
          if (end_of_frame) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && out_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (end_of_frame) begin
        wr_ptr_q    <= '0;
        frame_len_q <= word_cnt;
      end else if (accept) begin
        wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
      end

      if (end_of_frame || replay_go || (pop && out_last)) rd_ptr_q <= '0;
      else if (rd_en)                                      rd_ptr_q <= rd_ptr_q + (AWIDTH+1)'(1);

      rd_inflight_q <= rd_en;
      rd_last_q     <= rd_is_last;

      if (rd_inflight_q) begin
        fifo_data_q[fifo_wr_idx_q] <= ram_out;
        fifo_last_q[fifo_wr_idx_q] <= rd_last_q;
        fifo_wr_idx_q              <= !fifo_wr_idx_q;
      end
      if (pop) fifo_rd_idx_q <= !fifo_rd_idx_q;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_spram_stream_ctrl.sv
// Directed bench for spram_stream_ctrl with a behavioural single-port RAM and an output scoreboard.
module tb_spram_stream_ctrl;
  localparam int AW = 11;
  localparam int NW = 2048;
  localparam int DW = 60;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          replay = 1'b0;
  logic          busy;
  logic [AW:0]   frame_len;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_out;

  always #5 clk = ~clk;

  spram_stream_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .replay(replay), .busy(busy), .frame_len(frame_len),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_out(ram_out)
  );

  logic [DW-1:0] mem [NW];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    else          ram_out <= mem[ram_address];
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_pop = 0;
  int            exp_wr = 0;
  bit            stall_q = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;
  int            cyc;
  int            fv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle's handshakes, then advances to the next falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      chk("wr_en", 64'(ram_wren), 64'(1));
      chk("wr_addr", 64'(ram_address), 64'(exp_wr));
      chk("wr_data", 64'(ram_data), 64'(in_data));
      exp_wr = (in_last || exp_wr == NW - 1) ? 0 : exp_wr + 1;
    end
    if (busy) chk("drain_wren", 64'(ram_wren), 64'(0));
    if (stall_q) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data", 64'(out_data), 64'(held_d));
      chk("stall_last", 64'(out_last), 64'(held_l));
    end
    stall_q = out_valid && !out_ready;
    held_d  = out_data;
    held_l  = out_last;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_last", 64'(out_last), 64'(e.l));
        n_pop++;
      end
    end
    @(negedge clk);
  endtask

  task automatic write_frame(input int n, input logic [DW-1:0] base, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      in_last  = use_last && (i == n - 1);
      sb.push_back({in_data, (i == n - 1) ? 1'b1 : 1'b0});
      cycle();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_drain(input int maxc, input bit rnd, output int cycles, output int first_v);
    cycles  = 0;
    first_v = -1;
    while (busy && cycles < maxc) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (out_valid && first_v < 0) first_v = cycles;
      cycle();
      cycles++;
    end
    out_ready = 1'b1;
    chk("drain_done", 64'(busy), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
    chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    chk({tag, "_frame_len"}, 64'(frame_len), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_wren"}, 64'(ram_wren), 64'(0));
  endtask

  initial begin
    // Reset state, then in_ready rises as soon as reset drops.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Four-word frame, latency and throughput.
    write_frame(4, 60'h1, 1'b1);
    chk("len4", 64'(frame_len), 64'(4));
    chk("busy_entry4", 64'(busy), 64'(1));
    chk("valid_entry4", 64'(out_valid), 64'(0));
    chk("in_ready_drain", 64'(in_ready), 64'(0));
    run_drain(100, 1'b0, cyc, fv);
    chk("first_valid4", 64'(fv), 64'(2));
    chk("cycles4", 64'(cyc), 64'(6));

    // Single all-ones word.
    write_frame(1, 60'hFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("len1", 64'(frame_len), 64'(1));
    run_drain(100, 1'b0, cyc, fv);
    chk("cycles1", 64'(cyc), 64'(3));
    chk("in_ready_idle1", 64'(in_ready), 64'(1));

    // Full-depth frame without in_last terminates itself.
    write_frame(NW, 60'h0, 1'b0);
    chk("len2048", 64'(frame_len), 64'(NW));
    run_drain(3000, 1'b0, cyc, fv);
    chk("cycles2048", 64'(cyc), 64'(NW + 2));

    // Eight words with a randomly stalling consumer.
    write_frame(8, 60'h100, 1'b1);
    chk("len8", 64'(frame_len), 64'(8));
    run_drain(400, 1'b1, cyc, fv);

    // Reset while the third word of a ten-word frame is at the output.
    write_frame(10, 60'h200, 1'b1);
    n_pop = 0;
    cyc   = 0;
    while (n_pop < 2 && cyc < 50) begin
      cycle();
      cyc++;
    end
    chk("pre_reset_pops", 64'(n_pop), 64'(2));
    chk("pre_reset_valid", 64'(out_valid), 64'(1));
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    sb.delete();
    stall_q = 1'b0;
    exp_wr  = 0;
    @(negedge clk);
    reset = 1'b0;
    write_frame(2, 60'h300, 1'b1);
    chk("len2", 64'(frame_len), 64'(2));
    run_drain(100, 1'b0, cyc, fv);
    chk("cycles2", 64'(cyc), 64'(4));

    // Replay of a stored three-word frame.
    write_frame(3, 60'h400, 1'b1);
    run_drain(100, 1'b0, cyc, fv);
`ifdef SPRAM_STREAM_REPLAY_EN
    for (int i = 0; i < 3; i++) sb.push_back({60'h400 + DW'(i), (i == 2) ? 1'b1 : 1'b0});
    replay = 1'b1;
    cycle();
    replay = 1'b0;
    chk("replay_busy", 64'(busy), 64'(1));
    run_drain(100, 1'b0, cyc, fv);
    chk("replay_first_valid", 64'(fv), 64'(2));
    chk("replay_cycles", 64'(cyc), 64'(5));
`else
    replay = 1'b1;
    cycle();
    cycle();
    replay = 1'b0;
    chk("replay_ignored_busy", 64'(busy), 64'(0));
    chk("replay_ignored_valid", 64'(out_valid), 64'(0));
    chk("replay_ignored_ready", 64'(in_ready), 64'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
